// File: rtl/div_16_pkg.sv
// div_16_pkg: shared state encoding and sizing for the iterative divider
package div_16_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/div_16_sub.sv
// div_sub: combinational a - b as a + ~b + 1; borrow is the inverted carry out
module div_sub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W:0] w_sum;
  assign w_sum  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
  assign diff   = w_sum[W-1:0];
  assign borrow = ~w_sum[W];
endmodule

// File: rtl/div_16.sv
// div_16: restoring radix-2 unsigned divider, one quotient bit per clock
module div_16
  import div_16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_borrow;
  // R' drops the always-zero top bit of R and pulls in the next dividend bit
  assign w_r_shift = (WIDTH+1)'({r_r, r_q[WIDTH-1]});
  div_sub #(.W(WIDTH+1)) u_sub (
    .a      (w_r_shift),
    .b      ({1'b0, r_d}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );
  assign w_r_next = w_borrow ? w_r_shift : w_diff;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_q         <= dividend;
          r_r         <= '0;
          r_d         <= divisor;
          r_cnt       <= '0;
          busy        <= 1'b1;
          div_by_zero <= (divisor == '0);
          if (divisor == '0) begin
            r_state   <= S_DONE;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= dividend;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state   <= S_DONE;
            done      <= 1'b1;
            quotient  <= w_q_next;
            remainder <= w_r_next[WIDTH-1:0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_16.sv
// tb_div_16: table-driven, hand-sequenced and randomized checks of div_16
module tb_div_16;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;
  vec_t vecs[8];
  div_16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                        input logic [15:0] er, input logic ez, input string name);
    int k;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    chk({name, " busy"}, 32'(busy), 32'd1);
    if (b != 0) chk({name, " dz cleared"}, 32'(div_by_zero), 32'd0);
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, k, (b == 0) ? 32'd0 : 32'd16);
    chk({name, " quotient"}, 32'(quotient), 32'(eq));
    chk({name, " remainder"}, 32'(remainder), 32'(er));
    chk({name, " dz"}, 32'(div_by_zero), 32'(ez));
    if (b != 0) chk({name, " invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
    @(negedge clk);
    chk({name, " done pulse"}, 32'(done), 32'd0);
    chk({name, " busy off"}, 32'(busy), 32'd0);
  endtask
  initial begin
    int k;
    int seen;
    logic [15:0] a;
    logic [15:0] b;
    vecs[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0};
    vecs[3] = '{16'd3, 16'd10, 16'd0, 16'd3, 1'b0};
    vecs[4] = '{16'd0, 16'd5, 16'd0, 16'd0, 1'b0};
    vecs[5] = '{16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1};
    vecs[6] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0};
    vecs[7] = '{16'h8000, 16'h8001, 16'd0, 16'h8000, 1'b0};
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset q", 32'(quotient), 32'd0);
    chk("reset r", 32'(remainder), 32'd0);
    chk("reset dz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));
    // start mid-run and during the done cycle must both be ignored
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(negedge clk);
    start = 1'b0;
    k = 5;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ignore latency", k, 32'd16);
    chk("ignore q", 32'(quotient), 32'd14);
    chk("ignore r", 32'(remainder), 32'd2);
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("done-cycle start ignored", 32'(busy), 32'd0);
    chk("done-cycle q held", 32'(quotient), 32'd14);
    run_op(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, "after ignore");
    // asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    chk("async rst q", 32'(quotient), 32'd0);
    chk("async rst r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no done after rst", seen, 32'd0);
    run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, "after rst");
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 15));
        1: b = 16'($urandom_range(0, 255));
        default: b = 16'($urandom);
      endcase
      run_op(a, b, (b == 0) ? 16'hFFFF : a / b, (b == 0) ? a : a % b, b == 0, $sformatf("rnd%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
